// File: rtl/saturn_bus_ram.sv
// saturn_bus_ram: nibble-serial RAM peer on the saturn_core external bus.
// Keeps private PC/DP pointers and serves a 2**ADDR_BITS-nibble window at a
// base address that is claimed with CONFIGURE and released with UNCONFIGURE.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_bus_reset          bus reset from the core, same effect as i_reset
//   i_bus_strobe         one-cycle pulse per nibble transfer
//   i_bus_cmd_data       1 = command nibble, 0 = data nibble
//   i_bus_data_in[3:0]   nibble from the core
//   i_wprot              write protect (only with SATURN_BUS_RAM_WPROT_EN)
//   o_bus_data_out[3:0]  read nibble, 0 when not driving
//   o_bus_drive          device owns the read data of this transfer
//   o_configured         base address latched, device live
//
// Optional feature macro: SATURN_BUS_RAM_WPROT_EN adds i_wprot, which
// suppresses writes while high (pointers still advance, reads unaffected).

module saturn_bus_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_bus_reset,
  input  logic       i_bus_strobe,
  input  logic       i_bus_cmd_data,
  input  logic [3:0] i_bus_data_in,
`ifdef SATURN_BUS_RAM_WPROT_EN
  input  logic       i_wprot,
`endif
  output logic [3:0] o_bus_data_out,
  output logic       o_bus_drive,
  output logic       o_configured
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [3:0] CMD_PC_READ  = 4'h0;
  localparam logic [3:0] CMD_PC_WRITE = 4'h1;
  localparam logic [3:0] CMD_DP_READ  = 4'h2;
  localparam logic [3:0] CMD_DP_WRITE = 4'h3;
  localparam logic [3:0] CMD_LOAD_PC  = 4'h4;
  localparam logic [3:0] CMD_LOAD_DP  = 4'h5;
  localparam logic [3:0] CMD_CONFIG   = 4'h6;
  localparam logic [3:0] CMD_UNCONFIG = 4'h7;
  localparam logic [3:0] CMD_RESET    = 4'hF;

  // Load target encoding equals the low two bits of commands 4..7.
  localparam logic [1:0] TGT_PC    = 2'd0;
  localparam logic [1:0] TGT_DP    = 2'd1;
  localparam logic [1:0] TGT_CFG   = 2'd2;
  localparam logic [1:0] TGT_UNCFG = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PC_RD,
    S_PC_WR,
    S_DP_RD,
    S_DP_WR
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] pc_q, pc_d;
  logic [19:0] dp_q, dp_d;
  logic [19:0] base_q, base_d;
  logic        cfg_q, cfg_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [19:0] sh_q, sh_d;
  logic        drive_q, drive_d;
  logic [3:0]  dout_q, dout_d;

  logic [3:0]  mem_q [DEPTH];

  logic                 rst;
  logic                 wprot;
  logic                 use_pc;
  logic [19:0]          ptr;
  logic [19:0]          rel;
  logic                 hit;
  logic [ADDR_BITS-1:0] off;
  logic                 we;

  assign rst = i_reset | i_bus_reset;

`ifdef SATURN_BUS_RAM_WPROT_EN
  assign wprot = i_wprot;
`else
  assign wprot = 1'b0;
`endif

  // Window decode: distance from base, modulo 2**20, must fit the window.
  assign use_pc = (state_q == S_PC_RD) || (state_q == S_PC_WR);
  assign ptr    = use_pc ? pc_q : dp_q;
  assign rel    = ptr - base_q;
  assign hit    = cfg_q && (rel[19:ADDR_BITS] == '0);
  assign off    = rel[ADDR_BITS-1:0];

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      dp_q    <= '0;
      base_q  <= '0;
      cfg_q   <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= TGT_PC;
      sh_q    <= '0;
      drive_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dp_q    <= dp_d;
      base_q  <= base_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      sh_q    <= sh_d;
      drive_q <= drive_d;
      dout_q  <= dout_d;
    end
  end

  // RAM contents survive every kind of reset.
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem_q[off] <= i_bus_data_in;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dp_d    = dp_q;
    base_d  = base_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    sh_d    = sh_q;
    drive_d = drive_q;
    dout_d  = dout_q;
    we      = 1'b0;

    if (i_bus_strobe) begin
      // Read data is held only until the next strobe of any kind.
      drive_d = 1'b0;
      dout_d  = '0;

      if (i_bus_cmd_data) begin
        unique case (i_bus_data_in)
          CMD_PC_READ:  state_d = S_PC_RD;
          CMD_PC_WRITE: state_d = S_PC_WR;
          CMD_DP_READ:  state_d = S_DP_RD;
          CMD_DP_WRITE: state_d = S_DP_WR;
          CMD_LOAD_PC,
          CMD_LOAD_DP,
          CMD_CONFIG,
          CMD_UNCONFIG: begin
            state_d = S_ADDR;
            cnt_d   = '0;
            tgt_d   = i_bus_data_in[1:0];
          end
          CMD_RESET: begin
            state_d = S_IDLE;
            pc_d    = '0;
            dp_d    = '0;
            base_d  = '0;
            cfg_d   = 1'b0;
          end
          default:      state_d = S_IDLE;
        endcase
      end else begin
        unique case (state_q)
          S_PC_RD,
          S_DP_RD: begin
            drive_d = hit;
            dout_d  = hit ? mem_q[off] : 4'h0;
          end
          S_PC_WR,
          S_DP_WR: begin
            we = hit && !wprot && !rst;
          end
          S_ADDR: begin
            // Nibbles arrive least significant first.
            sh_d  = {i_bus_data_in, sh_q[19:4]};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
              state_d = S_IDLE;
              unique case (tgt_q)
                TGT_PC:    pc_d = sh_d;
                TGT_DP:    dp_d = sh_d;
                TGT_CFG: begin
                  if (!cfg_q) begin
                    base_d = sh_d;
                    cfg_d  = 1'b1;
                  end
                end
                TGT_UNCFG: begin
                  if (sh_d == base_q) begin
                    cfg_d = 1'b0;
                  end
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase

        // Pointers advance on every data strobe, hit or miss.
        unique case (state_q)
          S_PC_RD, S_PC_WR: pc_d = pc_q + 20'd1;
          S_DP_RD, S_DP_WR: dp_d = dp_q + 20'd1;
          default: ;
        endcase
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    o_bus_data_out = dout_q;
    o_bus_drive    = drive_q;
    o_configured   = cfg_q;
  end

endmodule

// File: tb/tb_saturn_bus_ram.sv
// tb_saturn_bus_ram: directed bench for saturn_bus_ram with a bus-level
// reference model checked every cycle plus literal spot checks.

module tb_saturn_bus_ram;

  localparam int AB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       brst = 1'b0;
  logic       strb = 1'b0;
  logic       cd = 1'b0;
  logic [3:0] din = 4'h0;
  logic       wp = 1'b0;
  logic [3:0] dout;
  logic       drive;
  logic       cfg;

  saturn_bus_ram #(.ADDR_BITS(AB)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_bus_reset    (brst),
    .i_bus_strobe   (strb),
    .i_bus_cmd_data (cd),
    .i_bus_data_in  (din),
`ifdef SATURN_BUS_RAM_WPROT_EN
    .i_wprot        (wp),
`endif
    .o_bus_data_out (dout),
    .o_bus_drive    (drive),
    .o_configured   (cfg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model: bus-level view of the device.
  int          m_mode;
  int          m_cnt;
  bit [19:0]   m_acc;
  bit [19:0]   m_pc, m_dp, m_base;
  bit          m_cfg;
  bit          m_wp;
  logic        m_drv;
  logic [3:0]  m_dat;
  logic [3:0]  m_mem [int];

  task automatic check(input string name, input logic [19:0] act,
                       input logic [19:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = -1;
    m_cnt  = 0;
    m_acc  = '0;
    m_pc   = '0;
    m_dp   = '0;
    m_base = '0;
    m_cfg  = 1'b0;
    m_drv  = 1'b0;
    m_dat  = 4'h0;
  endtask

  task automatic model_step(input bit c, input logic [3:0] n);
    bit [19:0] ptr;
    bit [19:0] rel;
    bit        hit;
    int        off;
    m_drv = 1'b0;
    m_dat = 4'h0;
    if (c) begin
      if (n <= 4'h3) m_mode = n;
      else if (n <= 4'h7) begin
        m_mode = n;
        m_cnt  = 0;
        m_acc  = '0;
      end else if (n == 4'hF) begin
        model_reset();
      end else m_mode = -1;
    end else if (m_mode >= 0 && m_mode <= 3) begin
      ptr = (m_mode <= 1) ? m_pc : m_dp;
      rel = ptr - m_base;
      hit = m_cfg && (rel < (1 << AB));
      off = int'(rel);
      if (m_mode == 0 || m_mode == 2) begin
        m_drv = hit;
        if (hit) m_dat = m_mem.exists(off) ? m_mem[off] : 4'hx;
      end else if (hit && !m_wp) begin
        m_mem[off] = n;
      end
      if (m_mode <= 1) m_pc = m_pc + 20'd1;
      else m_dp = m_dp + 20'd1;
    end else if (m_mode >= 4) begin
      m_acc = m_acc | (20'(n) << (4 * m_cnt));
      m_cnt++;
      if (m_cnt == 5) begin
        case (m_mode)
          4: m_pc = m_acc;
          5: m_dp = m_acc;
          6: if (!m_cfg) begin
               m_base = m_acc;
               m_cfg  = 1'b1;
             end
          default: if (m_acc == m_base) m_cfg = 1'b0;
        endcase
        m_mode = -1;
      end
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("drive", {19'd0, drive}, {19'd0, m_drv});
      check("data", {16'd0, dout}, {16'd0, m_dat});
      check("configured", {19'd0, cfg}, {19'd0, m_cfg});
    end
  end

  task automatic strobe(input bit c, input logic [3:0] n);
    @(negedge clk);
    strb = 1'b1;
    cd   = c;
    din  = n;
    @(posedge clk);
    #1;
    strb = 1'b0;
    cd   = 1'b0;
    din  = 4'h0;
    model_step(c, n);
  endtask

  task automatic load(input logic [3:0] cmd, input logic [19:0] v);
    strobe(1'b1, cmd);
    for (int i = 0; i < 5; i++) strobe(1'b0, v[4*i +: 4]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    m_wp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_drive", {19'd0, drive}, 20'd0);
    check("rst_data", {16'd0, dout}, 20'd0);
    check("rst_cfg", {19'd0, cfg}, 20'd0);

    // Unconfigured device never drives.
    strobe(1'b1, 4'h0);
    strobe(1'b0, 4'h0);
    check("unconf_drive", {19'd0, drive}, 20'd0);

    // CONFIGURE, then a second CONFIGURE is discarded.
    load(4'h6, 20'h08000);
    check("cfg_on", {19'd0, cfg}, 20'd1);
    check("model_base", m_base, 20'h08000);
    load(4'h6, 20'h09000);
    check("model_base2", m_base, 20'h08000);

    // Write A,B,C via DP, read back via PC.
    load(4'h5, 20'h08000);
    strobe(1'b1, 4'h3);
    strobe(1'b0, 4'hA);
    strobe(1'b0, 4'hB);
    strobe(1'b0, 4'hC);
    load(4'h4, 20'h08000);
    strobe(1'b1, 4'h0);
    strobe(1'b0, 4'h0);
    check("rdA", {16'd0, dout}, 20'hA);
    check("rdA_drv", {19'd0, drive}, 20'd1);
    idle(2);
    check("rdA_hold", {16'd0, dout}, 20'hA);
    strobe(1'b0, 4'h0);
    check("rdB", {16'd0, dout}, 20'hB);
    strobe(1'b0, 4'h0);
    check("rdC", {16'd0, dout}, 20'hC);

    // Top of window hits, one past misses.
    load(4'h5, 20'h083FF);
    strobe(1'b1, 4'h3);
    strobe(1'b0, 4'h7);
    load(4'h4, 20'h083FF);
    strobe(1'b1, 4'h0);
    strobe(1'b0, 4'h0);
    check("edge_hit", {19'd0, drive}, 20'd1);
    check("edge_data", {16'd0, dout}, 20'h7);
    strobe(1'b0, 4'h0);
    check("edge_miss", {19'd0, drive}, 20'd0);
    check("edge_miss_d", {16'd0, dout}, 20'h0);

    // Aborted DP load leaves DP at 08000.
    load(4'h5, 20'h08000);
    strobe(1'b1, 4'h5);
    strobe(1'b0, 4'h1);
    strobe(1'b0, 4'h2);
    strobe(1'b1, 4'h2);
    strobe(1'b0, 4'h0);
    check("abort_rd", {16'd0, dout}, 20'hA);
    check("model_dp", m_dp, 20'h08001);

    // Unknown command goes idle.
    strobe(1'b1, 4'h9);
    strobe(1'b0, 4'h5);
    check("unk_drive", {19'd0, drive}, 20'd0);

    // UNCONFIGURE needs a matching base.
    load(4'h7, 20'h09000);
    check("uncfg_miss", {19'd0, cfg}, 20'd1);
    load(4'h7, 20'h08000);
    check("uncfg_hit", {19'd0, cfg}, 20'd0);

    // Pointer wrap FFFFF -> 00000 with base 0.
    load(4'h6, 20'h00000);
    load(4'h5, 20'hFFFFF);
    strobe(1'b1, 4'h3);
    strobe(1'b0, 4'h9);
    strobe(1'b0, 4'h3);
    load(4'h4, 20'hFFFFF);
    strobe(1'b1, 4'h0);
    strobe(1'b0, 4'h0);
    check("wrap_miss", {19'd0, drive}, 20'd0);
    strobe(1'b0, 4'h0);
    check("wrap_rd", {16'd0, dout}, 20'h3);
    check("model_pc", m_pc, 20'h00001);

`ifdef SATURN_BUS_RAM_WPROT_EN
    wp = 1'b1;
    m_wp = 1'b1;
    load(4'h5, 20'h00000);
    strobe(1'b1, 4'h3);
    strobe(1'b0, 4'h5);
    wp = 1'b0;
    m_wp = 1'b0;
    load(4'h4, 20'h00000);
    strobe(1'b1, 4'h0);
    strobe(1'b0, 4'h0);
    check("wprot_rd", {16'd0, dout}, 20'h3);
`endif

    // RESET command.
    strobe(1'b1, 4'hF);
    check("rstcmd_cfg", {19'd0, cfg}, 20'd0);

    // i_reset mid-write, later writes ignored.
    load(4'h6, 20'h00000);
    load(4'h5, 20'h00010);
    strobe(1'b1, 4'h3);
    strobe(1'b0, 4'h6);
    do_reset();
    check("midrst_cfg", {19'd0, cfg}, 20'd0);
    strobe(1'b0, 4'h7);
    strobe(1'b1, 4'h3);
    strobe(1'b0, 4'h7);
    load(4'h6, 20'h00000);
    load(4'h4, 20'h00010);
    strobe(1'b1, 4'h0);
    strobe(1'b0, 4'h0);
    check("midrst_kept", {16'd0, dout}, 20'h6);
    load(4'h4, 20'h00000);
    strobe(1'b1, 4'h0);
    strobe(1'b0, 4'h0);
    check("midrst_ign", {16'd0, dout}, 20'h3);

    idle(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
